// File: rtl/lc3b_types.sv
// Shared LC-3b types: the machine word and the load unit's state encoding.
package lc3b_types;

   typedef logic [15:0] lc3b_word;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_DONE = 2'd2
   } load_state_t;

endpackage

// File: rtl/byte_select_extend.sv
// Picks a word or one byte of a memory word and zero/sign-extends the byte.
module byte_select_extend
   import lc3b_types::*;
(
   input  lc3b_word rdata,
   input  logic     addr0,
   input  logic     byte_check,
   input  logic     sign_ext,
   output lc3b_word result
);

   logic [7:0] byte_val;

   always_comb begin
      byte_val = addr0 ? rdata[15:8] : rdata[7:0];
      if (!byte_check) begin
         result = rdata;
      end else if (sign_ext) begin
         result = {{8{byte_val[7]}}, byte_val};
      end else begin
         result = {8'h00, byte_val};
      end
   end

endmodule

// File: rtl/byte_load_unit.sv
// LDB/LDW load unit: one word-aligned memory read per request, with byte
// select/extend and a bounded wait for the memory response.
module byte_load_unit
   import lc3b_types::*;
#(
   parameter int MAX_WAIT = 255
)
(
   input  logic     clk,
   input  logic     rst_n,
   input  logic     start,
   input  lc3b_word address,
   input  logic     byte_check,
   input  logic     sign_ext,
   output lc3b_word mem_address,
   output logic     mem_read,
   input  logic     mem_resp,
   input  lc3b_word mem_rdata,
   output logic     busy,
   output logic     done,
   output logic     error,
   output lc3b_word data_out
);

   localparam int CW = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;
   localparam logic [CW-1:0] WAIT_LIMIT = CW'(MAX_WAIT);

   load_state_t   state_q, state_d;
   lc3b_word      addr_q;
   logic          byte_q;
   logic          sext_q;
   logic [CW-1:0] wait_cnt;
   lc3b_word      data_q;
   logic          error_q;
   lc3b_word      sel_result;
   logic          accept;
   logic          timeout;

   // Handshake: mem_read stays high for every REQ cycle; the cycle in which
   // mem_resp is high is the cycle whose mem_rdata is consumed.
   assign accept  = (state_q == ST_IDLE) && start;
   assign timeout = (state_q == ST_REQ) && !mem_resp && (wait_cnt == WAIT_LIMIT);

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: if (start) state_d = ST_REQ;
         ST_REQ: begin
            if (mem_resp)     state_d = ST_DONE;
            else if (timeout) state_d = ST_IDLE;
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= ST_IDLE;
         addr_q   <= '0;
         byte_q   <= 1'b0;
         sext_q   <= 1'b0;
         wait_cnt <= '0;
         data_q   <= '0;
         error_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         error_q <= timeout;
         if (accept) begin
            addr_q   <= address;
            byte_q   <= byte_check;
            sext_q   <= sign_ext;
            wait_cnt <= '0;
         end else if ((state_q == ST_REQ) && !mem_resp && (wait_cnt != WAIT_LIMIT)) begin
            // Saturates at the limit; the timeout leaves REQ on that same cycle.
            wait_cnt <= wait_cnt + CW'(1);
         end
         if ((state_q == ST_REQ) && mem_resp) begin
            data_q <= sel_result;
         end
      end
   end

   byte_select_extend u_bse (
      .rdata      (mem_rdata),
      .addr0      (addr_q[0]),
      .byte_check (byte_q),
      .sign_ext   (sext_q),
      .result     (sel_result)
   );

   assign mem_read    = (state_q == ST_REQ);
   assign busy        = (state_q != ST_IDLE);
   assign done        = (state_q == ST_DONE);
   assign error       = error_q;
   assign data_out    = data_q;
   assign mem_address = (state_q == ST_REQ) ? {addr_q[15:1], 1'b0} : 16'h0000;

endmodule

// File: tb/tb_byte_load_unit.sv
// Bench for byte_load_unit: directed and randomized loads against a
// reference computed from the load rules.
module tb_byte_load_unit;

   localparam int MW = 4;

   logic        clk;
   logic        rst_n;
   logic        start;
   logic [15:0] address;
   logic        byte_check;
   logic        sign_ext;
   logic [15:0] mem_address;
   logic        mem_read;
   logic        mem_resp;
   logic [15:0] mem_rdata;
   logic        busy;
   logic        done;
   logic        error;
   logic [15:0] data_out;

   int          n_cmp  = 0;
   int          n_fail = 0;
   logic [15:0] exp_data;
   logic [15:0] exp_q[$];

   byte_load_unit #(.MAX_WAIT(MW)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .start       (start),
      .address     (address),
      .byte_check  (byte_check),
      .sign_ext    (sign_ext),
      .mem_address (mem_address),
      .mem_read    (mem_read),
      .mem_resp    (mem_resp),
      .mem_rdata   (mem_rdata),
      .busy        (busy),
      .done        (done),
      .error       (error),
      .data_out    (data_out)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish (got timeout, required completion)");
      $fatal(1, "watchdog");
   end

   // Reference: word loads pass through; byte loads take the addressed byte.
   function automatic logic [15:0] ref_load(logic [15:0] a, logic [15:0] d, bit bc, bit se);
      int b;
      if (!bc) return d;
      b = (a % 2 == 1) ? (int'(d) / 256) : (int'(d) % 256);
      if (se && b >= 128) b = b + 65280;
      return 16'(b);
   endfunction

   // One full load; waits > MW means memory never answers.
   task automatic run_load(input logic [15:0] addr, input bit bc, input bit se,
                           input logic [15:0] rdata, input int waits,
                           input bit noise, input string tag);
      logic [19:0] obs, exp;
      logic [15:0] res;
      bit          resp_now;
      start = 1'b1; address = addr; byte_check = bc; sign_ext = se; mem_resp = 1'b0;
      @(negedge clk);
      obs = {mem_read, busy, done, error, mem_address};
      exp = 20'h0;
      n_cmp++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s idle_status: got %h required %h", tag, obs, exp);
      end
      @(posedge clk); #1;
      start = 1'b0;
      for (int k = 0; k <= MW; k++) begin
         resp_now  = (k == waits);
         mem_resp  = resp_now;
         mem_rdata = resp_now ? rdata : 16'($urandom);
         if (noise) begin
            start = 1'($urandom); address = 16'($urandom);
            byte_check = 1'($urandom); sign_ext = 1'($urandom);
         end
         @(negedge clk);
         obs = {mem_read, busy, done, error, mem_address};
         exp = {4'b1100, addr & 16'hFFFE};
         n_cmp++;
         if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s req_status[%0d]: got %h required %h", tag, k, obs, exp);
         end
         @(posedge clk); #1;
         if (resp_now) break;
      end
      start = 1'b0; mem_resp = 1'b0; mem_rdata = 16'($urandom);
      if (waits <= MW) begin
         res = ref_load(addr, rdata, bc, se);
         exp_q.push_back(res);
         @(negedge clk);
         obs = {mem_read, busy, done, error, mem_address};
         exp = {4'b0110, 16'h0000};
         n_cmp++;
         if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s done_status: got %h required %h", tag, obs, exp);
         end
         exp_data = exp_q.pop_front();
         n_cmp++;
         if (data_out !== exp_data) begin
            n_fail++;
            $display("FAIL %s data_out: got %h required %h", tag, data_out, exp_data);
         end
         @(posedge clk); #1;
      end else begin
         @(negedge clk);
         obs = {mem_read, busy, done, error, mem_address};
         exp = {4'b0001, 16'h0000};
         n_cmp++;
         if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s timeout_status: got %h required %h", tag, obs, exp);
         end
         n_cmp++;
         if (data_out !== exp_data) begin
            n_fail++;
            $display("FAIL %s timeout_data_held: got %h required %h", tag, data_out, exp_data);
         end
         @(posedge clk); #1;
         @(negedge clk);
         n_cmp++;
         if ({busy, error, done} !== 3'b000) begin
            n_fail++;
            $display("FAIL %s error_single_pulse: got %b required 000", tag, {busy, error, done});
         end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0; start = 1'b0; address = '0; byte_check = 1'b0;
      sign_ext = 1'b0; mem_resp = 1'b0; mem_rdata = '0;
      exp_data = 16'h0000;
      repeat (2) @(posedge clk);
      @(negedge clk);
      n_cmp++;
      if ({mem_read, busy, done, error, mem_address, data_out} !== 36'h0) begin
         n_fail++;
         $display("FAIL reset_state: got %h required 0",
                  {mem_read, busy, done, error, mem_address, data_out});
      end
      @(posedge clk); #1;
      rst_n = 1'b1;
   endtask

   task automatic test_word_load();
      run_load(16'h3001, 1'b0, 1'b0, 16'hBEEF, 0, 1'b0, "word_load");
   endtask

   task automatic test_byte_loads();
      run_load(16'h4001, 1'b1, 1'b1, 16'h80F7, 0, 1'b0, "byte_odd_sext");
      run_load(16'h4002, 1'b1, 1'b0, 16'h80F7, 1, 1'b0, "byte_even_zext");
      run_load(16'h4003, 1'b1, 1'b0, 16'h80F7, 2, 1'b0, "byte_odd_zext");
      run_load(16'h4004, 1'b1, 1'b1, 16'h80F7, 0, 1'b0, "byte_even_sext");
   endtask

   task automatic test_timeout();
      run_load(16'h5000, 1'b0, 1'b0, 16'h0000, MW + 1, 1'b0, "timeout");
   endtask

   task automatic test_timeout_boundary();
      run_load(16'h5002, 1'b0, 1'b0, 16'hA5C3, MW, 1'b0, "boundary_resp");
      run_load(16'h5005, 1'b1, 1'b1, 16'h7F12, MW - 1, 1'b0, "near_boundary");
   endtask

   task automatic test_capture();
      run_load(16'h6001, 1'b1, 1'b1, 16'hC3A5, 3, 1'b1, "capture_noise");
   endtask

   task automatic test_back_to_back();
      run_load(16'h7000, 1'b0, 1'b0, 16'h1234, 0, 1'b0, "b2b_first");
      run_load(16'h7010, 1'b0, 1'b0, 16'h1234, 0, 1'b0, "b2b_second");
   endtask

   task automatic test_idle_resp();
      mem_resp = 1'b1; mem_rdata = 16'hDEAD; start = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         n_cmp++;
         if ({mem_read, busy, done, error, data_out} !== {4'b0000, exp_data}) begin
            n_fail++;
            $display("FAIL idle_resp[%0d]: got %h required %h", i,
                     {mem_read, busy, done, error, data_out}, {4'b0000, exp_data});
         end
         @(posedge clk); #1;
      end
      mem_resp = 1'b0;
   endtask

   task automatic test_reset_mid_req();
      start = 1'b1; address = 16'h2223; byte_check = 1'b0; mem_resp = 1'b0;
      @(posedge clk); #1;
      start = 1'b0;
      @(posedge clk); #2;
      rst_n = 1'b0;
      exp_data = 16'h0000;
      #1;
      n_cmp++;
      if ({mem_read, busy, done, error, mem_address, data_out} !== 36'h0) begin
         n_fail++;
         $display("FAIL reset_mid_req: got %h required 0",
                  {mem_read, busy, done, error, mem_address, data_out});
      end
      mem_resp = 1'b1; mem_rdata = 16'h9999;
      @(posedge clk); #1;
      rst_n = 1'b1;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         n_cmp++;
         if ({mem_read, busy, done, error, mem_address, data_out} !== 36'h0) begin
            n_fail++;
            $display("FAIL late_resp_ignored[%0d]: got %h required 0", i,
                     {mem_read, busy, done, error, mem_address, data_out});
         end
         @(posedge clk); #1;
      end
      mem_resp = 1'b0;
      // Release reset between edges; the very next edge must take the start.
      rst_n = 1'b0;
      #3;
      rst_n = 1'b1;
      run_load(16'h0101, 1'b1, 1'b0, 16'h55AA, 0, 1'b0, "first_after_reset");
   endtask

   task automatic test_random();
      logic [15:0] a, d;
      bit          bc, se, nz;
      int          w;
      for (int i = 0; i < 30; i++) begin
         a  = 16'($urandom);
         d  = 16'($urandom);
         bc = 1'($urandom);
         se = 1'($urandom);
         nz = 1'($urandom);
         w  = $urandom_range(0, MW + 1);
         run_load(a, bc, se, d, w, nz, $sformatf("random[%0d]", i));
      end
   endtask

   initial begin
      test_reset();
      test_word_load();
      test_byte_loads();
      test_timeout();
      test_timeout_boundary();
      test_capture();
      test_back_to_back();
      test_idle_resp();
      test_reset_mid_req();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/byte_load_unit.md
BYTE_LOAD_UNIT -- requirements
Module: byte_load_unit

Interface
REQ-001 Parameter: MAX_WAIT, default 255, the maximum number of cycles to wait for mem_resp before aborting with an error.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst_n  input  1  reset, asynchronous and active-low.
REQ-004 start  input  1  one-cycle load request; sampled only in IDLE.
REQ-005 address  input  lc3b_word  byte address of the load.
REQ-006 byte_check  input  1  1 = byte load (LDB); 0 = word load (LDW).
REQ-007 sign_ext  input  1  byte loads only: 1 = sign-extend the byte, 0 = zero-extend it.
REQ-008 mem_address  output  lc3b_word  word-aligned memory address.
REQ-009 mem_read  output  1  memory read request.
REQ-010 mem_resp  input  1  memory response valid.
REQ-011 mem_rdata  input  lc3b_word  memory read data.
REQ-012 busy  output  1  high while a load is in progress.
REQ-013 done  output  1  one-cycle pulse when data_out is valid.
REQ-014 error  output  1  one-cycle pulse on timeout.
REQ-015 data_out  output  lc3b_word  registered load result; holds its value until the next done.

Function
REQ-016 The FSM SHALL have three states:
- IDLE -> REQ when start=1.
- REQ -> DONE when mem_resp=1.
- REQ -> IDLE (error pulse) on timeout.
- DONE -> IDLE unconditionally.
REQ-017 On accepting start, the block SHALL capture address, byte_check and sign_ext into internal registers; later input changes SHALL have no effect on the load in flight.
REQ-018 mem_address SHALL equal {captured address[15:1], 1'b0} while in REQ, and SHALL be 16'h0000 otherwise.
REQ-019 mem_read SHALL be high throughout REQ, with no gap, and low in IDLE and DONE.
REQ-020 Data path, with b = mem_rdata sampled in the cycle mem_resp=1:
- word load: data_out = b, and address[0] is ignored.
- byte load, address[0]=1: byte = b[15:8].
- byte load, address[0]=0: byte = b[7:0].
- extension: {8{byte[7]}, byte} when sign_ext=1, otherwise {8'h00, byte}.
REQ-021 data_out SHALL be registered on the mem_resp edge; done SHALL be high in the DONE state only, i.e. exactly one cycle after the mem_resp cycle.
REQ-022 Minimum latency SHALL be start -> done = 2 cycles plus memory wait cycles; back-to-back loads SHALL be possible with start asserted in the cycle after done.
REQ-023 busy SHALL be high in REQ and DONE.
REQ-024 start asserted while busy=1 SHALL be ignored; no queuing.
REQ-025 The wait counter SHALL clear on entry to REQ and increment each REQ cycle without mem_resp.
REQ-026 When the wait counter reaches MAX_WAIT with no mem_resp, the block SHALL:
- pulse error for one cycle;
- drop mem_read;
- return to IDLE with data_out unchanged.
REQ-027 mem_resp in the same cycle as the counter reaching MAX_WAIT SHALL complete normally, with no error.
REQ-028 mem_resp outside REQ SHALL be ignored.
REQ-029 The wait counter width SHALL be $clog2(MAX_WAIT+1) and SHALL saturate, never wrap.

Reset
REQ-030 Asserting rst_n=0 SHALL immediately force:
- state to IDLE;
- mem_read, busy, done and error to 0;
- data_out and mem_address to 16'h0000;
- the counter and captured registers to 0.
REQ-031 Reset mid-load (in REQ) SHALL abandon the request; a subsequent mem_resp SHALL be ignored.
REQ-032 After release of reset, the first start SHALL be accepted in the first clock edge with rst_n=1.

Structure
REQ-033 lc3b_word and an enumerated state type SHALL come from lc3b_types.
REQ-034 No new package constants SHALL be added beyond the state enum.
REQ-035 The combinational byte-select/extend logic SHALL be one sub-module, byte_select_extend, with inputs rdata, addr0, byte_check and sign_ext, and output the 16-bit result.

Verification
REQ-036 Word load: address=16'h3001, byte_check=0, mem_rdata=16'hBEEF after 0 wait cycles -> mem_address=16'h3000, data_out=16'hBEEF, done 2 cycles after start.
REQ-037 Byte loads with mem_rdata=16'h80F7:
- address odd, sign_ext=1 -> data_out=16'hFF80.
- address even, sign_ext=0 -> data_out=16'h00F7.
REQ-038 Timeout: MAX_WAIT=4, mem_resp never asserted -> error pulses once, mem_read drops, busy=0, data_out keeps its prior value.
REQ-039 Timeout boundary: mem_resp asserted in exactly the 4th wait cycle with MAX_WAIT=4 -> done, no error.
REQ-040 Input and reset robustness:
- start pulsed during REQ, and address changed mid-wait -> ignored; the result uses the captured address.
- rst_n low during REQ, then a late mem_resp -> all outputs 0, no done.
REQ-041 Back-to-back: start in the cycle after done with mem_rdata=16'h1234 word load -> second done exactly 2 cycles later, data_out=16'h1234.
